// File: rtl/cpu_types.sv
// cpu_types: shared types for the decode/issue/execute slice.
//   IQ_DEPTH  default issue queue depth
//   opcode_t  decoded operation class
//   task_t    one decoded instruction as it travels decode -> issue -> execute
//   is_ctrl / is_mem  opcode class helpers used by the pairing rules
package cpu_types;

  localparam int IQ_DEPTH = 8;

  typedef enum logic [3:0] {
    OP     = 4'd0,
    NOP    = 4'd1,
    LOAD   = 4'd2,
    STORE  = 4'd3,
    BRANCH = 4'd4,
    JAL    = 4'd5,
    JALR   = 4'd6
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_used;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] pc;
  } task_t;

  function automatic logic is_ctrl(input opcode_t op);
    return (op == BRANCH) || (op == JAL) || (op == JALR);
  endfunction

  function automatic logic is_mem(input opcode_t op);
    return (op == LOAD) || (op == STORE);
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// issue_queue_if: decode-side enqueue, execute-side issue, writeback completion
// and flush signals of the issue queue.
//   master  : driven by the surrounding pipeline (decode, execute, writeback)
//   slave   : seen by the issue queue
//   TASK_0/TASK_1, valid_0/valid_1, in_ready   enqueue pair (TASK_0 older)
//   ISSUE_0/ISSUE_1, issue_valid_0/1, issue_ready   issue pair
//   cmpl_valid, cmpl_rd_addr   writeback clears busy register
//   flush   discard queued entries;  count   occupancy
interface issue_queue_if import cpu_types::*; #(
  parameter int DEPTH = IQ_DEPTH
) ();

  task_t                  TASK_0;
  task_t                  TASK_1;
  logic                   valid_0;
  logic                   valid_1;
  logic                   in_ready;
  task_t                  ISSUE_0;
  task_t                  ISSUE_1;
  logic                   issue_valid_0;
  logic                   issue_valid_1;
  logic                   issue_ready;
  logic                   cmpl_valid;
  logic [4:0]             cmpl_rd_addr;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output TASK_0, TASK_1, valid_0, valid_1, issue_ready,
           cmpl_valid, cmpl_rd_addr, flush,
    input  in_ready, ISSUE_0, ISSUE_1, issue_valid_0, issue_valid_1, count
  );

  modport slave (
    input  TASK_0, TASK_1, valid_0, valid_1, issue_ready,
           cmpl_valid, cmpl_rd_addr, flush,
    output in_ready, ISSUE_0, ISSUE_1, issue_valid_0, issue_valid_1, count
  );

endinterface

// File: rtl/iq_hazard_check.sv
// iq_hazard_check: combinational issue decision for the two oldest entries.
//   cand_0/cand_1   entry present and (for slot 0) issue allowed this cycle
//   task_0/task_1   oldest and second-oldest entries
//   busy            registered register scoreboard
//   issue_valid_0/1 slot issues this cycle
module iq_hazard_check import cpu_types::*; (
  input  logic        cand_0,
  input  logic        cand_1,
  input  task_t       task_0,
  input  task_t       task_1,
  input  logic [31:0] busy,
  output logic        issue_valid_0,
  output logic        issue_valid_1
);

  // Sources and a nonzero destination must all be idle in the scoreboard.
  function automatic logic regs_free(input task_t t, input logic [31:0] b);
    return !(t.rs1_used && b[t.rs1_addr]) &&
           !(t.rs2_used && b[t.rs2_addr]) &&
           !(t.rd_used && (t.rd_addr != 5'd0) && b[t.rd_addr]);
  endfunction

  // Rules that only matter when both entries go out together.
  function automatic logic pair_ok(input task_t t0, input task_t t1);
    logic writes0, raw, waw;
    writes0 = t0.rd_used && (t0.rd_addr != 5'd0);
    raw = writes0 && ((t1.rs1_used && (t1.rs1_addr == t0.rd_addr)) ||
                      (t1.rs2_used && (t1.rs2_addr == t0.rd_addr)));
    waw = writes0 && t1.rd_used && (t1.rd_addr == t0.rd_addr);
    return !raw && !waw && !is_ctrl(t0.opcode) &&
           !(is_mem(t0.opcode) && is_mem(t1.opcode));
  endfunction

  assign issue_valid_0 = cand_0 && regs_free(task_0, busy);
  assign issue_valid_1 = issue_valid_0 && cand_1 && regs_free(task_1, busy) &&
                         pair_ok(task_0, task_1);

endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order dual-enqueue / dual-issue queue with a register busy
// scoreboard, between dual decode and the execute units.
//   CLK  clock;  RST  synchronous active-high reset
//   bus  issue_queue_if.slave: enqueue pair, issue pair, completion, flush, count
module issue_queue import cpu_types::*; #(
  parameter int DEPTH = IQ_DEPTH
) (
  input logic          CLK,
  input logic          RST,
  issue_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  task_t            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_1;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy;
  logic [31:0]      busy_next;
  logic             in_ready;
  logic             cand_0;
  logic             cand_1;
  logic             iv0;
  logic             iv1;
  logic [1:0]       enq_n;
  logic [1:0]       iss_n;

  assign head_1   = head + PTR_W'(1);
  // Pairs enqueue atomically, so one free slot is not enough.
  assign in_ready = (count <= CNT_W'(DEPTH - 2));
  assign cand_0   = (count != '0) && bus.issue_ready && !bus.flush;
  assign cand_1   = (count >= CNT_W'(2));
  assign enq_n    = in_ready ? ({1'b0, bus.valid_0} + {1'b0, bus.valid_1}) : 2'd0;
  assign iss_n    = {1'b0, iv0} + {1'b0, iv1};

  iq_hazard_check u_hazard (
    .cand_0       (cand_0),
    .cand_1       (cand_1),
    .task_0       (mem[head]),
    .task_1       (mem[head_1]),
    .busy         (busy),
    .issue_valid_0(iv0),
    .issue_valid_1(iv1)
  );

  assign bus.in_ready      = in_ready;
  assign bus.ISSUE_0       = mem[head];
  assign bus.ISSUE_1       = mem[head_1];
  assign bus.issue_valid_0 = iv0;
  assign bus.issue_valid_1 = iv1;
  assign bus.count         = count;

  // Clear on completion first so a same-register set in this cycle wins.
  always_comb begin
    busy_next = busy;
    if (bus.cmpl_valid) busy_next[bus.cmpl_rd_addr] = 1'b0;
    if (iv0 && bus.ISSUE_0.rd_used) busy_next[bus.ISSUE_0.rd_addr] = 1'b1;
    if (iv1 && bus.ISSUE_1.rd_used) busy_next[bus.ISSUE_1.rd_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Entry storage: data only, not reset. A lone TASK_1 takes the tail slot.
  always_ff @(posedge CLK) begin
    if (in_ready) begin
      if (bus.valid_0) mem[tail] <= bus.TASK_0;
      if (bus.valid_1) mem[tail + PTR_W'(bus.valid_0)] <= bus.TASK_1;
    end
  end

  // Pointers, occupancy and scoreboard. Flush keeps busy: in-flight work
  // still completes and must clear its destination.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
    end else begin
      busy <= busy_next;
      if (bus.flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + PTR_W'(iss_n);
        tail  <= tail + PTR_W'(enq_n);
        count <= count + CNT_W'(enq_n) - CNT_W'(iss_n);
      end
    end
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

In-order, dual-enqueue, dual-issue instruction queue between the dual-decode stage and the execute units. It buffers up to `DEPTH` decoded `task_t` entries and keeps a register busy scoreboard. Each cycle it issues the oldest one or two entries whose source and destination registers are free and that pass the pairing rules. Register-writing tasks mark their `rd` busy at issue, and the writeback completion port clears it.

## Interface
- `DEPTH`, 8: queue entries; power of two, at least 4.
- `CLK`  in  1: the only clock; all state updates on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `TASK_0`, `TASK_1`  in  `task_t`: decoded tasks; `TASK_0` is the older instruction in program order.
- `valid_0`, `valid_1`  in  1: the corresponding task is present this cycle.
- `in_ready`  out  1: at least 2 entries are free; enqueue happens only when this is high.
- `ISSUE_0`, `ISSUE_1`  out  `task_t`: oldest entry and second-oldest entry.
- `issue_valid_0`, `issue_valid_1`  out  1: the corresponding slot issues this cycle.
- `issue_ready`  in  1: execute accepts issue this cycle; when low, nothing issues.
- `cmpl_valid`  in  1: a writeback is completing this cycle.
- `cmpl_rd_addr`  in  5: destination register of the completing instruction.
- `flush`  in  1: discard all queued entries (branch redirect).
- `count`  out  `$clog2(DEPTH)+1`: current occupancy.

## Operation
- **Storage:** circular buffer with `head`/`tail` pointers of width `$clog2(DEPTH)`, wrapping modulo `DEPTH`.
- **Enqueue:** only when `in_ready`=1. Valid tasks are written at `tail` in order, `TASK_0` first. If `valid_1`=1 and `valid_0`=0, `TASK_1` takes the single slot at `tail`. `tail` advances by the number of valid tasks. Valids while `in_ready`=0 are ignored; the upstream stage must hold its tasks.
- **Scoreboard:** `busy[31:0]`. `busy[0]` is always 0.
- **Slot 0 eligibility** (`issue_valid_0`): all of the following hold.
  - `count`≥1 and `issue_ready`=1.
  - If `rs1_used`, then `busy[rs1_addr]`=0.
  - If `rs2_used`, then `busy[rs2_addr]`=0.
  - If `rd_used` and `rd_addr`≠0, then `busy[rd_addr]`=0. This is the WAW stall.
- **Slot 1 eligibility** (`issue_valid_1`): `issue_valid_0`=1, `count`≥2, the slot 0 rules above applied to entry `head+1`, and all of the following.
  - No RAW against slot 0: if slot 0 has `rd_used` and `rd`≠0, slot 1's used `rs1`/`rs2` must not equal slot 0's `rd`.
  - No WAW against slot 0: slot 1's `rd` must not equal slot 0's `rd` when both are used and nonzero.
  - Slot 0 opcode is not BRANCH, JAL or JALR.
  - Slot 0 and slot 1 are not both LOAD/STORE.
- **Issue effects:** `head` advances by the number issued. For each issued task with `rd_used` and `rd`≠0, `busy[rd]` is set at the edge.
- **Completion:** `cmpl_valid` clears `busy[cmpl_rd_addr]` at the edge. If a set and a clear target the same register in one cycle, the set wins. The WAW check prevents this case in normal operation.
- **Eligibility timing:** eligibility uses the registered `busy`. A completion in cycle N unblocks dependants in cycle N+1. There is no bypass.
- **Flush:** at the edge, `head`, `tail` and `count` go to 0. Same-cycle enqueue is discarded and issue is suppressed (`issue_valid_*`=0 while `flush`=1). `busy` is kept, because in-flight instructions still complete.
- **Occupancy:** `count_next = count + enq_n - iss_n`, with `enq_n` and `iss_n` in 0..2. Simultaneous enqueue and issue are legal at any occupancy.

## Timing
- **Reset values:** `count`=0, `head`=`tail`=0, `busy`=0, `issue_valid_*`=0, `in_ready`=1.
- `ISSUE_*` are don't-care when their valid is 0; the bench must not check them.
- **Combinational outputs:** `in_ready` is `DEPTH-count ≥ 2`. `ISSUE_*` and `issue_valid_*` are combinational from registered state plus `issue_ready`/`flush`.
- **Latency:** a task enqueued at edge N is issuable at the earliest in cycle N+1.
- **Full:** at `count`=`DEPTH-1`, `in_ready`=0 even though one slot is free. This keeps enqueue atomic for pairs.
- **Empty:** at `count`=0, nothing issues and there is no enqueue-to-issue bypass.
- **Reset mid-operation:** `RST` overrides every other input in the same cycle.

## Structure
- Use `task_t` and `opcode_t` (BRANCH, JAL, JALR, LOAD, STORE, OP, NOP, …) from `cpu_types`.
- Add `IQ_DEPTH` to `cpu_types` as the default source for `DEPTH`.
- Sub-module `iq_hazard_check`: purely combinational. It takes two candidate tasks plus `busy` and returns `issue_valid_0`/`issue_valid_1`. This keeps the pairing rules testable in isolation.

## Test plan
- **Independent pair:** reset, then enqueue OP x1←x2,x3 and OP x4←x5,x6. Next cycle both issue; `busy[1]`=`busy[4]`=1; `count`=0.
- **RAW in pair, then completion:** enqueue x1←x2,x3 and x7←x1,x2.
  - Only slot 0 issues. Slot 1 then stalls on `busy[1]`.
  - Drive `cmpl_valid`, `cmpl_rd_addr`=1. The dependant issues the following cycle.
- **Fill and wrap:** hold `issue_ready`=0 and enqueue pairs.
  - With `DEPTH`=8, `in_ready` drops when `count`=7 (after 3 pairs plus 1 single).
  - Release `issue_ready` and drain. Order is preserved across pointer wrap.
- **Pairing rules:**
  - BRANCH followed by OP: only the BRANCH issues in that cycle.
  - LOAD followed by STORE: they issue in separate cycles.
  - Writes to x0: never stall and never set `busy`.
- **Flush:** with 5 entries queued and `busy[9]`=1, assert `flush` together with valid tasks. Next cycle `count`=0, `busy[9]` is still 1, and the flushed tasks never issue.
